// File: rtl/arp_tx_sched.sv
// ARP reply transmit scheduler: ping-pong capture of reply bytes, reply queueing,
// and round-robin sharing of the Ethernet transmitter with a UDP source plus timeout.
module arp_tx_sched #(
    parameter int TIMEOUT = 2047
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] arp_bus,
    input  logic        udp_req,
    input  logic        tx_busy,
    input  logic        tx_done,
    input  logic [3:0]  arp_raddr,
    output logic [7:0]  arp_rdata,
    output logic        tx_start,
    output logic        tx_sel,
    output logic        udp_grant,
    output logic [1:0]  arp_pend,
    output logic [7:0]  drop_cnt,
    output logic [7:0]  tmo_cnt
);
    typedef enum logic [1:0] {IDLE, ARP_TX, UDP_TX} state_t;

    localparam logic [10:0] TMO = 11'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [1:0][9:0][7:0]   mem_q, mem_d;
    logic [3:0]             wptr_q, wptr_d;
    logic                   wsel_q, wsel_d;
    logic                   rsel_q, rsel_d;
    logic [1:0]             full_q, full_d;
    logic                   last_q, last_d;
    logic [10:0]            cnt_q, cnt_d;
    logic [7:0]             drop_q, drop_d;
    logic [7:0]             tmo_q, tmo_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   start_q, start_d;

    logic bus_ok, bus_stb, bus_wr;
    logic [7:0] bus_data;
    logic grant_arp, grant_udp, in_tx, tmo_hit, leave;

    assign {bus_ok, bus_stb, bus_wr, bus_data} = arp_bus;

    assign grant_arp = (state_q == IDLE) && !tx_busy && full_q[rsel_q] && (!udp_req || last_q);
    assign grant_udp = (state_q == IDLE) && !tx_busy && !grant_arp && udp_req;
    assign in_tx     = (state_q != IDLE);
    assign tmo_hit   = in_tx && (cnt_q == TMO);
    assign leave     = in_tx && (tx_done || tmo_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mem_q   <= '0;
            wptr_q  <= '0;
            wsel_q  <= 1'b0;
            rsel_q  <= 1'b0;
            full_q  <= '0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            drop_q  <= '0;
            tmo_q   <= '0;
            rdata_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            wsel_q  <= wsel_d;
            rsel_q  <= rsel_d;
            full_q  <= full_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_arp)      state_d = ARP_TX;
                else if (grant_udp) state_d = UDP_TX;
            end
            ARP_TX, UDP_TX: if (leave) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        wsel_d  = wsel_q;
        rsel_d  = rsel_q;
        full_d  = full_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        tmo_d   = tmo_q;
        start_d = grant_arp || grant_udp;

        if (bus_wr && (wptr_q < 4'd10) && !full_q[wsel_q]) begin
            mem_d[wsel_q][wptr_q] = bus_data;
            wptr_d = wptr_q + 4'd1;
        end

        // Capture side decides on the pre-update flags; the release below may
        // still clear the same slot flag in this cycle.
        if (bus_stb) begin
            wptr_d = '0;
            if (bus_ok && full_q[wsel_q]) begin
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end else if (bus_ok && (wptr_q == 4'd10)) begin
                full_d[wsel_q] = 1'b1;
                wsel_d = ~wsel_q;
            end
        end

        if (grant_arp || grant_udp) cnt_d = '0;
        else if (in_tx)             cnt_d = cnt_q + 11'd1;

        if (leave) begin
            last_d = (state_q == UDP_TX);
            if (!tx_done && tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
            if (state_q == ARP_TX) begin
                full_d[rsel_q] = 1'b0;
                rsel_d = ~rsel_q;
            end
        end

        rdata_d = (arp_raddr < 4'd10) ? mem_q[rsel_q][arp_raddr] : 8'h00;
    end

    always_comb begin
        tx_sel    = (state_q == UDP_TX);
        udp_grant = (state_q == UDP_TX);
        tx_start  = start_q;
        arp_rdata = rdata_q;
        arp_pend  = full_q;
        drop_cnt  = drop_q;
        tmo_cnt   = tmo_q;
    end
endmodule

// File: doc/arp_tx_sched.md
# arp_tx_sched

Transmit scheduler between the ARP receive path and the shared Ethernet transmitter. It captures the 10 reply bytes (sender MAC and IP) carried on `arp_bus` into a two-slot ping-pong buffer. It queues a reply for each validated request and shares the transmitter with an external UDP packet source using round-robin arbitration and a transmit timeout. The ARP reply builder reads the captured bytes back through a registered read port while its reply is granted.

## Interface
Parameters:
- `TIMEOUT`, 2047: cycles allowed between `tx_start` and `tx_done` before the grant is forcibly released. Legal range is 1..2047.

Ports:
- `clk` input 1: single clock.
- `rst` input 1: asynchronous reset, active-high.
- `arp_bus` input 11: {ok, strobe, write, data[7:0]} from the ARP receiver.
- `udp_req` input 1: level; UDP source has a packet ready.
- `tx_busy` input 1: transmitter is not ready to accept a new packet.
- `tx_done` input 1: one-cycle pulse at the end of the granted packet.
- `arp_raddr` input 4: byte index 0..9 into the slot being transmitted.
- `arp_rdata` output 8: registered read data.
- `tx_start` output 1: one-cycle pulse when a grant begins.
- `tx_sel` output 1: 0 = ARP owns the transmitter, 1 = UDP owns it; valid while a grant is active.
- `udp_grant` output 1: level, high for the whole UDP grant.
- `arp_pend` output 2: `slot_full` flags.
- `drop_cnt` output 8: saturating count of validated requests dropped because the buffer was full.
- `tmo_cnt` output 8: saturating count of timeouts.

## Operation
- Capture pointer `wptr` is 4 bits. Each cycle with `write`=1 and `wptr`<10 and `slot_full[wsel]`=0:
  - store `data` at slot `wsel`, index `wptr`;
  - increment `wptr`.
- A write is ignored when `wptr`=10 or when `slot_full[wsel]`=1.
- On `strobe`=1:
  - If `ok`=1, `wptr`=10 and `slot_full[wsel]`=0: set `slot_full[wsel]` and toggle `wsel`.
  - If `ok`=1 and `slot_full[wsel]`=1: increment `drop_cnt`, saturating at 255.
  - In every other case discard silently.
  - `wptr` returns to 0 in all cases.
- Read slot `rsel` starts at 0. Slots are consumed in order.
- Arbiter FSM states are IDLE, ARP_TX and UDP_TX. Flag `last` records the most recently served source (0 = ARP, 1 = UDP; reset 1).
- IDLE, when `tx_busy`=0:
  - Grant ARP if `slot_full[rsel]`=1 and (`udp_req`=0 or `last`=1).
  - Otherwise grant UDP if `udp_req`=1.
  - On either grant: pulse `tx_start`, load the timeout counter with 0, enter ARP_TX or UDP_TX.
- ARP_TX and UDP_TX:
  - The counter increments every cycle.
  - On `tx_done`, or when the counter reaches `TIMEOUT`, return to IDLE and set `last` to the served source.
  - On a timeout, increment `tmo_cnt` (saturating at 255).
  - Leaving ARP_TX, for either reason, clears `slot_full[rsel]` and toggles `rsel`.
- `tx_done` in IDLE is ignored.
- `arp_rdata` is loaded with slot `rsel`, index `arp_raddr`, every cycle. Indices 10..15 read 0.

## Timing
- Reset values: all outputs 0, except `tx_sel`=0 and `udp_grant`=0. FSM is IDLE, `wsel`=`rsel`=0, `wptr`=0, `last`=1. Reset mid-grant aborts immediately and does not count as a timeout.
- Strobe to `arp_pend` set: 1 cycle.
- Pending to `tx_start`: 1 cycle, given IDLE and `tx_busy`=0. Back-to-back grants therefore have at least one IDLE cycle between them.
- `tx_sel` and `udp_grant` change on the same edge as `tx_start`. They return to 0 on the edge that leaves the grant state.
- `arp_rdata` latency is 1 cycle from `arp_raddr`.
- A strobe that sets slot A in the same cycle as the ARP_TX exit that clears slot B: both take effect.
- A strobe in the same cycle as the exit that frees `wsel`'s slot: the flag is sampled before the update, so that request is dropped.
- Timeout fires on the cycle the counter equals `TIMEOUT`, i.e. `TIMEOUT`+1 cycles after `tx_start`, unless `tx_done` occurs first.
- `tx_done` and timeout on the same cycle: counted as done, `tmo_cnt` unchanged.

## Test plan
- Single request:
  - Stimulus: 10 writes of 0x10..0x19, then strobe with ok=1, `udp_req`=0.
  - Required: `arp_pend`=01 one cycle later; `tx_start` the next cycle with `tx_sel`=0; reading `arp_raddr`=3 gives 0x13; after `tx_done`, `arp_pend`=00.
- Invalid capture:
  - Stimulus: strobe with ok=0, and separately 9 writes followed by strobe with ok=1.
  - Required: no slot set, `drop_cnt`=0, `tx_start` never asserted.
- Overflow:
  - Stimulus: `tx_busy`=1 and three valid requests.
  - Required: `arp_pend`=11, `drop_cnt`=1; after releasing `tx_busy`, replies go out from slot 0 then slot 1.
- Round robin:
  - Stimulus: `udp_req` held high with two ARP replies pending.
  - Required: grant order ARP, UDP, ARP, UDP.
- Timeout:
  - Stimulus: `TIMEOUT`=20, ARP grant with no `tx_done`.
  - Required: grant released 21 cycles after `tx_start`, `tmo_cnt`=1, slot freed.
- Asynchronous reset:
  - Stimulus: `rst` asserted mid-UDP grant.
  - Required: `udp_grant`=0 immediately, without waiting for a clock edge; `arp_pend`=00 and counters 0.
